uart_instr_link: RTL and testbench
==================================

Name: uart_instr_link

Overview:
- UART link between the host and the single-step processor harness.
- Receiver: assembles four 8N1 bytes from `rx` into a 32-bit instruction word and pulses `instruction_rcv` when the word is complete.
- Transmitter: sends one byte per `tx_start` handshake on `tx`; the harness uses it to stream the register file back byte by byte.
- Both halves share one clock and one divider.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate; BIT_CYCLES = CLK_HZ/BAUD, integer-truncated (104 at the defaults).
- RX_TIMEOUT_BYTES, 8, partial-word timeout in byte times; used only with RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (clk12 domain); all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- instruction  out  32  last complete received word.
- instruction_rcv  out  1  one-cycle pulse when `instruction` updates.
- tx_data  in  8  byte to transmit.
- tx_start  in  1  transmit request; level, may be held.
- tx  out  1  serial output, idle high.
- tx_ready  out  1  high when the transmitter is idle and can accept `tx_start`.

Behaviour:
- Reset: `tx`=1, `tx_ready`=1, `instruction`=0, `instruction_rcv`=0; byte counter = 0; both FSMs idle.
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- Frame format: 8N1, LSB first, each bit lasting BIT_CYCLES clocks.
- RX input conditioning: `rx` passes through a 2-flop synchronizer before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START: at BIT_CYCLES/2, if the line is still low go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits at each bit centre (every BIT_CYCLES).
  - STOP: sample at the stop-bit centre, then return to IDLE. A high stop bit marks a valid byte.
- Framing error (stop bit low): byte discarded, byte counter cleared, no pulse; wait for the line to return high before re-arming.
- Word assembly is little-endian:
  - Byte k (0..3) goes to bits [8k+7:8k] of a shadow register.
  - On the 4th valid byte, `instruction` <= shadow and `instruction_rcv` = 1 for exactly one cycle, in the cycle after the stop-bit sample.
  - Counter wraps to 0 after byte 3.
- `instruction` holds its value until the next complete word; partial words never alter it.
- TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE with `tx_start`=1: latch `tx_data`; `tx_ready` drops to 0 in the next cycle and `tx` goes low (start bit).
  - Then 8 data bits, LSB first, then the stop bit (1).
  - `tx_ready` returns to 1 after the full stop-bit period.
- `tx_start` while busy is ignored. A held `tx_start` re-triggers only once `tx_ready` is 1 again.
- `tx_data` changes during a frame have no effect.
- Mid-frame reset: `tx` returns to 1 immediately (asynchronous), all in-flight data is discarded, and the partial word is dropped.
- RX and TX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro: UART_INSTR_LINK_RX_TIMEOUT_EN.
- Defined: a counter runs while the byte counter ≠ 0 and the RX FSM is IDLE. After RX_TIMEOUT_BYTES×10×BIT_CYCLES clocks without a new start bit, the byte counter clears, so a lost byte cannot permanently misalign words.
- Undefined: no timeout; a partial word persists indefinitely.

Decomposition:
- Package uart_instr_pkg holds:
  - BIT_CYCLES / half-bit computation function;
  - RX and TX state enum typedefs;
  - BYTES_PER_WORD=4.
- One sub-module, uart_rx_byte: synchronizer + RX FSM, outputs byte[7:0] and byte_valid.
- The top level holds word assembly, the timeout and the TX FSM.

Test Plan:
- Reset: assert rst mid-run -> `tx`=1, `tx_ready`=1, `instruction`=0, `instruction_rcv`=0; deassert -> idle.
- RX word: send bytes 0x13,0x00,0x00,0x00 at 104 clk/bit -> one `instruction_rcv` pulse, `instruction`=32'h00000013. Follow with EF,BE,AD,DE -> 32'hDEADBEEF.
- RX error: a 20-cycle low glitch, then a byte with stop bit=0, then 4 good bytes -> no byte accepted from the glitch or the bad frame; only the final word 32'h04030201 (bytes 01,02,03,04) is produced.
- TX byte: `tx_data`=0xA5, pulse `tx_start` -> `tx_ready`=0 next cycle; line shows 0,1,0,1,0,0,1,0,1,1, each 104 cycles; `tx_ready`=1 after 1040 cycles.
- TX handshake: hold `tx_start` high through 2 frames with `tx_data` changed mid-frame -> each frame carries the value latched at its start; no frame is truncated.
- Timeout (macro defined): send 2 bytes, idle 8 byte times, send 4 bytes -> `instruction` equals the last 4 bytes. Without the macro -> word formed from bytes 1–4 of the stream.

Source files
------------

// File: rtl/uart_instr_link_pkg.sv
// Shared constants, bit-timing helpers and FSM state encodings for the UART instruction link.
package uart_instr_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_bit(input int bit_len);
        return bit_len / 2;
    endfunction

endpackage

// File: rtl/uart_instr_link_if.sv
// Host-side signal bundle of the UART instruction link; slave = link, master = host/harness.
// Handshake: tx_start is a level request, accepted only on a cycle where tx_ready is 1.
interface uart_instr_link_if;
    logic        rx;
    logic [31:0] instruction;
    logic        instruction_rcv;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx;
    logic        tx_ready;
    logic [1:0]  rx_state_dbg;
    logic [1:0]  tx_state_dbg;

    modport slave (
        input  rx, tx_data, tx_start,
        output instruction, instruction_rcv, tx, tx_ready, rx_state_dbg, tx_state_dbg
    );

    modport master (
        output rx, tx_data, tx_start,
        input  instruction, instruction_rcv, tx, tx_ready, rx_state_dbg, tx_state_dbg
    );
endinterface

// File: rtl/uart_instr_link_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, start-bit glitch rejection, centre sampling.
// byte_valid_o / frame_err_o are single-cycle strobes on the stop-bit sample cycle.
module uart_rx_byte
    import uart_instr_pkg::*;
#(
    parameter int BIT_CYCLES = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(BIT_CYCLES) - 1);

    localparam logic [1:0] S_IDLE  = RX_IDLE;
    localparam logic [1:0] S_START = RX_START;
    localparam logic [1:0] S_DATA  = RX_DATA;
    localparam logic [1:0] S_STOP  = RX_STOP;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A falling edge needs a high line first, so a low line after a bad frame never re-arms.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                    byte_valid_o = rx_sync_q;
                    frame_err_o  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign byte_o  = shift_q;
    assign state_o = state_q;
endmodule

// File: rtl/uart_instr_link.sv
// UART instruction link: 4-byte little-endian word receiver plus single-byte transmitter.
// Optional macro UART_INSTR_LINK_RX_TIMEOUT_EN clears a stale partial word after an idle timeout.
module uart_instr_link
    import uart_instr_pkg::*;
#(
    parameter int CLK_HZ           = 12000000,
    parameter int BAUD             = 115200,
    parameter int RX_TIMEOUT_BYTES = 8
) (
    input  logic clk,
    input  logic rst,
    uart_instr_link_if.slave link
);
    localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [1:0] WORD_LAST = 2'(BYTES_PER_WORD - 1);

    localparam logic [1:0] RXS_IDLE = RX_IDLE;
    localparam logic [1:0] S_IDLE   = TX_IDLE;
    localparam logic [1:0] S_START  = TX_START;
    localparam logic [1:0] S_DATA   = TX_DATA;
    localparam logic [1:0] S_STOP   = TX_STOP;

    logic [7:0] rx_byte;
    logic       rx_byte_valid, rx_frame_err, timeout_hit;
    logic [1:0] rx_state;

    uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (link.rx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_byte_valid),
        .frame_err_o  (rx_frame_err),
        .state_o      (rx_state)
    );

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shadow_q, shadow_d;
    logic [31:0] instr_q, instr_d;
    logic        rcv_q, rcv_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        instr_d    = instr_q;
        rcv_d      = 1'b0;
        if (rx_frame_err) begin
            byte_cnt_d = '0;
        end else if (rx_byte_valid) begin
            if (byte_cnt_q == WORD_LAST) begin
                instr_d    = {rx_byte, shadow_q};
                rcv_d      = 1'b1;
                byte_cnt_d = '0;
            end else begin
                case (byte_cnt_q)
                    2'd0:    shadow_d[7:0]   = rx_byte;
                    2'd1:    shadow_d[15:8]  = rx_byte;
                    default: shadow_d[23:16] = rx_byte;
                endcase
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end else if (timeout_hit) begin
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= '0;
            shadow_q   <= '0;
            instr_q    <= '0;
            rcv_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            instr_q    <= instr_d;
            rcv_q      <= rcv_d;
        end
    end

`ifdef UART_INSTR_LINK_RX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = RX_TIMEOUT_BYTES * 10 * BIT_CYCLES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_armed;

    assign to_armed    = (byte_cnt_q != 2'd0) && (rx_state == RXS_IDLE);
    assign timeout_hit = to_armed && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_armed && !timeout_hit) to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |RX_TIMEOUT_BYTES;
    assign timeout_hit        = 1'b0;
`endif

    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d, tx_ready_q, tx_ready_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            S_IDLE: begin
                if (link.tx_start) begin
                    tx_shift_d = link.tx_data;
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                    tx_ready_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign link.instruction     = instr_q;
    assign link.instruction_rcv = rcv_q;
    assign link.tx              = tx_q;
    assign link.tx_ready        = tx_ready_q;
    assign link.rx_state_dbg    = rx_state;
    assign link.tx_state_dbg    = tx_state_q;
endmodule

// File: tb/tb_uart_instr_link.sv
// Directed bench for uart_instr_link: RX word assembly, RX error rejection, TX framing/handshake, reset.
module tb_uart_instr_link;
    import uart_instr_pkg::*;

    localparam int BC = 104;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rcv_pulses = 0;
    logic [31:0] last_word = '0;

    uart_instr_link_if link_if ();

    uart_instr_link dut (
        .clk  (clk),
        .rst  (rst),
        .link (link_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (link_if.instruction_rcv === 1'b1) begin
            rcv_pulses = rcv_pulses + 1;
            last_word  = link_if.instruction;
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        link_if.rx = 1'b0;
        repeat (BC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            link_if.rx = b[i];
            repeat (BC) @(negedge clk);
        end
        link_if.rx = stop;
        repeat (BC) @(negedge clk);
        link_if.rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Called one negedge after the edge that accepted tx_start; returns 10 mid-bit samples of tx.
    task automatic sample_frame(output logic [9:0] bits, input logic [7:0] mid_data);
        repeat (BC / 2) @(negedge clk);
        bits[0] = link_if.tx;
        for (int i = 1; i < 10; i++) begin
            repeat (BC) @(negedge clk);
            bits[i] = link_if.tx;
            if (i == 4) link_if.tx_data = mid_data;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (link_if.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", link_if.tx); end
        n_cmp++; if (link_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", link_if.tx_ready); end
        n_cmp++; if (link_if.instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instruction: got %h want 0", link_if.instruction); end
        n_cmp++; if (link_if.instruction_rcv !== 1'b0) begin n_fail++; $display("FAIL reset_rcv: got %b want 0", link_if.instruction_rcv); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (link_if.rx_state_dbg !== RX_IDLE) begin n_fail++; $display("FAIL reset_rx_state: got %0d want %0d", link_if.rx_state_dbg, RX_IDLE); end
        n_cmp++; if (link_if.tx_state_dbg !== TX_IDLE) begin n_fail++; $display("FAIL reset_tx_state: got %0d want %0d", link_if.tx_state_dbg, TX_IDLE); end
    endtask

    task automatic test_rx_word;
        int p0;
        p0 = rcv_pulses;
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        n_cmp++; if (rcv_pulses - p0 !== 1) begin n_fail++; $display("FAIL rx_word1_pulses: got %0d want 1", rcv_pulses - p0); end
        n_cmp++; if (link_if.instruction !== 32'h00000013) begin n_fail++; $display("FAIL rx_word1_value: got %h want 00000013", link_if.instruction); end
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
        n_cmp++; if (link_if.instruction !== 32'h00000013) begin n_fail++; $display("FAIL rx_partial_hold: got %h want 00000013", link_if.instruction); end
        n_cmp++; if (rcv_pulses - p0 !== 1) begin n_fail++; $display("FAIL rx_partial_pulses: got %0d want 1", rcv_pulses - p0); end
        send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        n_cmp++; if (rcv_pulses - p0 !== 2) begin n_fail++; $display("FAIL rx_word2_pulses: got %0d want 2", rcv_pulses - p0); end
        n_cmp++; if (link_if.instruction !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rx_word2_value: got %h want deadbeef", link_if.instruction); end
        n_cmp++; if (last_word !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rx_word2_at_pulse: got %h want deadbeef", last_word); end
    endtask

    task automatic test_rx_error;
        int p0;
        p0 = rcv_pulses;
        send_byte(8'h77, 1'b1);
        @(negedge clk);
        link_if.rx = 1'b0;
        repeat (20) @(negedge clk);
        link_if.rx = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++; if (link_if.rx_state_dbg !== RX_IDLE) begin n_fail++; $display("FAIL rx_glitch_state: got %0d want %0d", link_if.rx_state_dbg, RX_IDLE); end
        send_byte(8'h55, 1'b0);
        repeat (50) @(negedge clk);
        n_cmp++; if (rcv_pulses - p0 !== 0) begin n_fail++; $display("FAIL rx_bad_frame_pulses: got %0d want 0", rcv_pulses - p0); end
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        n_cmp++; if (rcv_pulses - p0 !== 1) begin n_fail++; $display("FAIL rx_error_pulses: got %0d want 1", rcv_pulses - p0); end
        n_cmp++; if (link_if.instruction !== 32'h04030201) begin n_fail++; $display("FAIL rx_error_value: got %h want 04030201", link_if.instruction); end
    endtask

    task automatic test_tx_byte;
        logic [9:0] bits;
        @(negedge clk);
        link_if.tx_data  = 8'hA5;
        link_if.tx_start = 1'b1;
        @(negedge clk);
        link_if.tx_start = 1'b0;
        n_cmp++; if (link_if.tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_drop: got %b want 0", link_if.tx_ready); end
        n_cmp++; if (link_if.tx !== 1'b0) begin n_fail++; $display("FAIL tx_start_bit: got %b want 0", link_if.tx); end
        sample_frame(bits, 8'h5A);
        n_cmp++; if (bits !== 10'b1101001010) begin n_fail++; $display("FAIL tx_a5_frame: got %b want 1101001010", bits); end
        repeat (51) @(negedge clk);
        n_cmp++; if (link_if.tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_early: got %b want 0 at cycle 1039", link_if.tx_ready); end
        @(negedge clk);
        n_cmp++; if (link_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_return: got %b want 1 at cycle 1040", link_if.tx_ready); end
        repeat (20) @(negedge clk);
        n_cmp++; if (link_if.tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle_line: got %b want 1", link_if.tx); end
    endtask

    task automatic test_tx_handshake;
        logic [9:0] bits;
        int waited;
        @(negedge clk);
        link_if.tx_data  = 8'h3C;
        link_if.tx_start = 1'b1;
        @(negedge clk);
        sample_frame(bits, 8'hC3);
        n_cmp++; if (bits !== 10'b1001111000) begin n_fail++; $display("FAIL tx_hold_frame1: got %b want 1001111000", bits); end
        repeat (52) @(negedge clk);
        n_cmp++; if (link_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_hold_gap_ready: got %b want 1", link_if.tx_ready); end
        @(negedge clk);
        n_cmp++; if ({link_if.tx_ready, link_if.tx} !== 2'b00) begin n_fail++; $display("FAIL tx_hold_retrigger: got ready,tx=%b want 00", {link_if.tx_ready, link_if.tx}); end
        link_if.tx_start = 1'b0;
        sample_frame(bits, 8'h99);
        n_cmp++; if (bits !== 10'b1110000110) begin n_fail++; $display("FAIL tx_hold_frame2: got %b want 1110000110", bits); end
        waited = 0;
        while (link_if.tx_ready !== 1'b1 && waited < 1200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (link_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_hold_final_ready: got %b want 1 within 1200 cycles", link_if.tx_ready); end
    endtask

    task automatic test_timeout;
        int p0;
        logic [31:0] exp_word;
`ifdef UART_INSTR_LINK_RX_TIMEOUT_EN
        exp_word = 32'h44332211;
`else
        exp_word = 32'h2211A2A1;
`endif
        p0 = rcv_pulses;
        send_byte(8'hA1, 1'b1); send_byte(8'hA2, 1'b1);
        repeat (8 * 10 * BC + 200) @(negedge clk);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        n_cmp++; if (rcv_pulses - p0 !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", rcv_pulses - p0); end
        n_cmp++; if (link_if.instruction !== exp_word) begin n_fail++; $display("FAIL timeout_value: got %h want %h", link_if.instruction, exp_word); end
    endtask

    task automatic test_reset_midrun;
        int p0;
        send_byte(8'h5A, 1'b1); send_byte(8'h6B, 1'b1);
        @(negedge clk);
        link_if.rx       = 1'b0;
        link_if.tx_data  = 8'h00;
        link_if.tx_start = 1'b1;
        @(negedge clk);
        link_if.tx_start = 1'b0;
        repeat (300) @(negedge clk);
        n_cmp++; if (link_if.tx !== 1'b0) begin n_fail++; $display("FAIL midrun_tx_busy: got %b want 0", link_if.tx); end
        rst = 1'b1;
        #1;
        n_cmp++; if (link_if.tx !== 1'b1) begin n_fail++; $display("FAIL midrun_tx_async: got %b want 1", link_if.tx); end
        n_cmp++; if (link_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_tx_ready: got %b want 1", link_if.tx_ready); end
        n_cmp++; if (link_if.instruction !== 32'h0) begin n_fail++; $display("FAIL midrun_instruction: got %h want 0", link_if.instruction); end
        n_cmp++; if (link_if.instruction_rcv !== 1'b0) begin n_fail++; $display("FAIL midrun_rcv: got %b want 0", link_if.instruction_rcv); end
        link_if.rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (link_if.tx_state_dbg !== TX_IDLE) begin n_fail++; $display("FAIL midrun_tx_state: got %0d want %0d", link_if.tx_state_dbg, TX_IDLE); end
        p0 = rcv_pulses;
        send_byte(8'h0A, 1'b1); send_byte(8'h0B, 1'b1); send_byte(8'h0C, 1'b1); send_byte(8'h0D, 1'b1);
        n_cmp++; if (rcv_pulses - p0 !== 1) begin n_fail++; $display("FAIL midrun_word_pulses: got %0d want 1", rcv_pulses - p0); end
        n_cmp++; if (link_if.instruction !== 32'h0D0C0B0A) begin n_fail++; $display("FAIL midrun_word_value: got %h want 0d0c0b0a", link_if.instruction); end
    endtask

    initial begin
        link_if.rx       = 1'b1;
        link_if.tx_data  = 8'h00;
        link_if.tx_start = 1'b0;
        test_reset();
        test_rx_word();
        test_rx_error();
        test_tx_byte();
        test_tx_handshake();
        test_timeout();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
